// File: rtl/tinyvga_dither_out.sv
// TinyVGA output stage: brightness scaling, 4x4 ordered dither to 2 bits per channel, frame counter.
// Optional TINYVGA_TEMPORAL_DITHER_EN: invert the Bayer x-phase on odd frames.
module tinyvga_dither_out (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] r_in,
    input  logic [4:0] g_in,
    input  logic [4:0] b_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    input  logic [1:0] pix_x_lo,
    input  logic [1:0] pix_y_lo,
    input  logic [2:0] bright,
    output logic [7:0] uo_out,
    output logic [9:0] frame_cnt
);

    localparam int unsigned CW = 5;
    localparam int unsigned PW = 8;
    localparam int unsigned DW = 6;
    localparam int unsigned FW = 10;

    // Scale a channel by (bright+1)/8; max product 31*8 = 248 fits in PW bits.
    function automatic logic [CW-1:0] scale(input logic [CW-1:0] v, input logic [2:0] br);
        logic [PW-1:0] p;
        p = PW'(v) * PW'({1'b0, br} + 4'd1);
        return CW'(p >> 3);
    endfunction

    // Dithered 2-bit level; the sum tops out at 63 so DW bits never overflow.
    function automatic logic [1:0] dither(input logic [CW-1:0] s, input logic [3:0] bayer);
        logic [DW-1:0] d;
        d = DW'(s) + DW'(s[4:1]) + DW'(bayer) + DW'(s[4]) + DW'(s[0]);
        return d[5:4];
    endfunction

    logic          phase_t;
    logic [1:0]    bi;
    logic [1:0]    bx;
    logic [3:0]    bayer;

`ifdef TINYVGA_TEMPORAL_DITHER_EN
    assign phase_t = frame_cnt[0];
`else
    assign phase_t = 1'b0;
`endif

    always_comb begin
        bi    = pix_x_lo ^ {2{phase_t}};
        bx    = bi ^ pix_y_lo;
        bayer = {bx[0], bi[0], bx[1], bi[1]};
    end

    logic [CW-1:0] s_r, s_g, s_b;
    logic          hs1, vs1, act1;
    logic [3:0]    bayer1;
    logic          vs_hist;

    // Stage 1: scaled colour plus timing and dither index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_r    <= '0;
            s_g    <= '0;
            s_b    <= '0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            act1   <= 1'b0;
            bayer1 <= '0;
        end else begin
            s_r    <= scale(r_in, bright);
            s_g    <= scale(g_in, bright);
            s_b    <= scale(b_in, bright);
            hs1    <= hsync_in;
            vs1    <= vsync_in;
            act1   <= active_in;
            bayer1 <= bayer;
        end
    end

    logic [1:0] r2, g2, b2;
    logic [7:0] uo_nxt;

    always_comb begin
        r2     = 2'b00;
        g2     = 2'b00;
        b2     = 2'b00;
        if (act1) begin
            r2 = dither(s_r, bayer1);
            g2 = dither(s_g, bayer1);
            b2 = dither(s_b, bayer1);
        end
        uo_nxt = {hs1, b2[0], g2[0], r2[0], vs1, b2[1], g2[1], r2[1]};
    end

    // Stage 2: pin register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uo_out <= '0;
        end else begin
            uo_out <= uo_nxt;
        end
    end

    // Frame counter on stage-1 vsync rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_hist   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_hist <= vs1;
            if (vs1 && !vs_hist) begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tinyvga_dither_out.sv
// Directed bench for tinyvga_dither_out: streamed vector table plus reset, sync, wrap and temporal sequences.
module tb_tinyvga_dither_out;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] r_in, g_in, b_in;
    logic       hsync_in, vsync_in, active_in;
    logic [1:0] pix_x_lo, pix_y_lo;
    logic [2:0] bright;
    logic [7:0] uo_out;
    logic [9:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tinyvga_dither_out dut (
        .clk       (clk),
        .reset     (reset),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .active_in (active_in),
        .pix_x_lo  (pix_x_lo),
        .pix_y_lo  (pix_y_lo),
        .bright    (bright),
        .uo_out    (uo_out),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] r, g, b;
        logic       hs, vs, act;
        logic [1:0] x, y;
        logic [2:0] br;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [4:0] r, g, b, input logic hs, vs, act,
                                input logic [1:0] x, y, input logic [2:0] br, input logic [7:0] exp);
        vec_t v;
        v.r = r; v.g = g; v.b = b; v.hs = hs; v.vs = vs; v.act = act;
        v.x = x; v.y = y; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        r_in = v.r; g_in = v.g; b_in = v.b;
        hsync_in = v.hs; vsync_in = v.vs; active_in = v.act;
        pix_x_lo = v.x; pix_y_lo = v.y; bright = v.br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t idle, pix;
    logic [7:0] exp_odd;

    initial begin
        // r,g,b, hs,vs,act, x,y, bright, expected uo_out
        vecs[0]  = mk(31,  0,  0, 0, 0, 1, 0, 0, 7, 8'h11);
        vecs[1]  = mk(16, 16, 16, 0, 0, 1, 0, 0, 7, 8'h70);
        vecs[2]  = mk(16, 16, 16, 0, 0, 1, 3, 3, 7, 8'h70);
        vecs[3]  = mk(16, 16, 16, 0, 0, 1, 1, 2, 7, 8'h07);
        vecs[4]  = mk(16, 16, 16, 0, 0, 1, 2, 0, 7, 8'h70);
        vecs[5]  = mk(16, 16, 16, 0, 0, 1, 3, 0, 7, 8'h07);
        vecs[6]  = mk(16, 16, 16, 0, 0, 1, 0, 1, 7, 8'h07);
        vecs[7]  = mk(31, 31, 31, 1, 0, 0, 0, 0, 7, 8'h80);
        vecs[8]  = mk(31,  0,  0, 0, 0, 1, 0, 0, 3, 8'h10);
        vecs[9]  = mk(31,  0,  0, 0, 0, 1, 3, 0, 0, 8'h10);
        vecs[10] = mk( 0,  0,  0, 0, 0, 1, 3, 0, 7, 8'h00);
        vecs[11] = mk( 5, 31, 10, 1, 0, 1, 0, 0, 7, 8'hA2);
        vecs[12] = mk( 0,  0, 20, 0, 0, 1, 1, 1, 5, 8'h40);
        vecs[13] = mk(16, 16, 16, 0, 0, 1, 2, 1, 7, 8'h07);
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 8'h00);

        // Reset held with random inputs
        reset = 1'b1;
        drive(idle);
        for (int i = 0; i < 4; i++) begin
            r_in = 5'($urandom); g_in = 5'($urandom); b_in = 5'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom); active_in = 1'($urandom);
            pix_x_lo = 2'($urandom); pix_y_lo = 2'($urandom); bright = 3'($urandom);
            tick();
            check("reset_uo", 16'(uo_out), 16'h00);
            check("reset_frame", 16'(frame_cnt), 16'h0);
        end

        // Release: first pixel appears on the second edge
        drive(vecs[0]);
        reset = 1'b0;
        tick();
        check("release_edge1", 16'(uo_out), 16'h00);
        tick();
        check("release_edge2", 16'(uo_out), 16'h11);

        // Streamed table, one pixel per cycle
        for (int j = 0; j <= NV; j++) begin
            if (j < NV) drive(vecs[j]);
            else drive(idle);
            tick();
            if (j >= 1) check($sformatf("vec%0d", j - 1), 16'(uo_out), 16'(vecs[j - 1].exp));
        end

        // Single vsync pulse: 2-cycle sync delay and frame count
        drive(idle);
        tick();
        tick();
        check("idle_uo", 16'(uo_out), 16'h00);
        vsync_in = 1'b1;
        tick();
        check("vs_edge1", 16'(uo_out), 16'h00);
        vsync_in = 1'b0;
        hsync_in = 1'b1;
        tick();
        check("vs_edge2", 16'(uo_out), 16'h08);
        check("frame_after_pulse", 16'(frame_cnt), 16'd1);
        tick();
        check("hs_edge2", 16'(uo_out), 16'h80);
        check("frame_hold", 16'(frame_cnt), 16'd1);

        // Temporal dither: x=0,y=0,s=8 on odd then even frame
        pix = mk(8, 0, 0, 0, 0, 1, 0, 0, 7, 8'h00);
`ifdef TINYVGA_TEMPORAL_DITHER_EN
        exp_odd = 8'h10;
`else
        exp_odd = 8'h00;
`endif
        drive(pix);
        tick(); tick(); tick();
        check("temporal_odd", 16'(uo_out), 16'(exp_odd));
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick(); tick(); tick();
        check("frame_two", 16'(frame_cnt), 16'd2);
        check("temporal_even", 16'(uo_out), 16'h00);

        // Mid-line asynchronous reset
        drive(vecs[0]);
        tick(); tick();
        check("pre_reset_uo", 16'(uo_out), 16'h11);
        reset = 1'b1;
        #1;
        check("async_reset_uo", 16'(uo_out), 16'h00);
        check("async_reset_frame", 16'(frame_cnt), 16'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_edge1", 16'(uo_out), 16'h00);
        tick();
        check("post_reset_edge2", 16'(uo_out), 16'h11);

        // 1025 vsync pulses from zero: wrap through 1023 -> 0 -> 1
        drive(idle);
        for (int p = 1; p <= 1025; p++) begin
            vsync_in = 1'b1;
            tick();
            vsync_in = 1'b0;
            tick();
            if (p == 1023) check("frame_1023", 16'(frame_cnt), 16'd1023);
            if (p == 1024) check("frame_wrap", 16'(frame_cnt), 16'd0);
            if (p == 1025) check("frame_1025", 16'(frame_cnt), 16'd1);
        end
        tick(); tick();
        check("frame_final", 16'(frame_cnt), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
